// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: decode load/store selects, FSM states
// and the misalignment rule used when LSU_MISALIGN_CHK_EN is defined.
package lsu_pkg;

   typedef enum logic [2:0] {
      LD_LB   = 3'd0,
      LD_LH   = 3'd1,
      LD_LW   = 3'd2,
      LD_LBU  = 3'd3,
      LD_LHU  = 3'd4,
      LD_NONE = 3'd5
   } ld_sel_e;

   typedef enum logic [1:0] {
      ST_SB = 2'd0,
      ST_SH = 2'd1,
      ST_SW = 2'd2
   } st_sel_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_e;

   localparam int DATA_W = 32;

   // Half accesses need an even address, word accesses a multiple of four.
   function automatic logic is_misaligned(input logic       we,
                                          input logic [2:0] ld_sel,
                                          input logic [1:0] st_sel,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (we) begin
         case (st_sel)
            ST_SB:   mis = 1'b0;
            ST_SH:   mis = addr_lo[0];
            default: mis = |addr_lo;
         endcase
      end else begin
         case (ld_sel)
            LD_LH, LD_LHU: mis = addr_lo[0];
            LD_LW:         mis = |addr_lo;
            default:       mis = 1'b0;
         endcase
      end
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte-enable/replication and load extraction with
// sign or zero extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_ld_sel,
   input  logic [1:0]  i_st_sel,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_bmask,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and half-word from the read word.
   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // Store lanes: replicate the datum across the word so any lane can take it.
   always_comb begin
      o_bmask = 4'b1111;
      o_wdata = i_st_data;
      if (i_we) begin
         case (i_st_sel)
            ST_SB: begin
               o_bmask = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_st_data[7:0]}};
            end
            ST_SH: begin
               o_bmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
               o_bmask = 4'b1111;
               o_wdata = i_st_data;
            end
         endcase
      end else begin
         o_bmask = 4'b1111;
         o_wdata = i_st_data;
      end
   end

   // Load extension.
   always_comb begin
      case (i_ld_sel)
         LD_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
         LD_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
         LD_LW:   o_ld_data = i_rdata;
         LD_LBU:  o_ld_data = {24'h000000, w_byte};
         LD_LHU:  o_ld_data = {16'h0000, w_half};
         default: o_ld_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded access into a word-aligned req/ack memory
// transaction. Define LSU_MISALIGN_CHK_EN to trap misaligned half/word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_mem_wren,
   input  logic [2:0]        i_ld_sel,
   input  logic [1:0]        i_st_sel,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_st_data,
   output logic              o_busy,
   output logic              o_done,
   output logic [31:0]       o_ld_data,
   output logic              o_misalign,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic              i_mem_ack,
   input  logic [31:0]       i_mem_rdata
);

   lsu_state_e        r_state;
   ld_sel_e           r_ld_sel;
   logic [1:0]        r_addr_lo;
   logic              r_done;
   logic              r_misalign;
   logic [31:0]       r_ld_data;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_bmask;

   logic              w_valid;
   logic              w_misalign;
   logic [1:0]        w_addr_lo;
   logic [3:0]        w_bmask;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ld_data;

   assign w_valid = i_req & (i_mem_wren | (i_ld_sel <= 3'd4));

`ifdef LSU_MISALIGN_CHK_EN
   assign w_misalign = is_misaligned(i_mem_wren, i_ld_sel, i_st_sel, i_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   // Store steering uses the live request in IDLE; load extraction uses the captured lane.
   assign w_addr_lo = (r_state == S_IDLE) ? i_addr[1:0] : r_addr_lo;

   lsu_align u_align (
      .i_we      (i_mem_wren),
      .i_ld_sel  (r_ld_sel),
      .i_st_sel  (i_st_sel),
      .i_addr_lo (w_addr_lo),
      .i_st_data (i_st_data),
      .i_rdata   (i_mem_rdata),
      .o_bmask   (w_bmask),
      .o_wdata   (w_wdata),
      .o_ld_data (w_ld_data)
   );

   // Access sequencer with registered memory-side and completion outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ld_sel    <= LD_LB;
         r_addr_lo   <= 2'b00;
         r_done      <= 1'b0;
         r_misalign  <= 1'b0;
         r_ld_data   <= 32'h0000_0000;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'h0000_0000;
         r_mem_bmask <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
               if (w_valid) begin
                  r_ld_sel  <= ld_sel_e'(i_ld_sel);
                  r_addr_lo <= i_addr[1:0];
                  if (w_misalign) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                     r_ld_data  <= 32'h0000_0000;
                  end else begin
                     r_state     <= S_REQ;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_mem_wren;
                     r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                     r_mem_wdata <= w_wdata;
                     r_mem_bmask <= i_mem_wren ? w_bmask : 4'b1111;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_ack) begin
                  r_state    <= S_DONE;
                  r_mem_req  <= 1'b0;
                  r_done     <= 1'b1;
                  r_misalign <= 1'b0;
                  r_ld_data  <= r_mem_we ? 32'h0000_0000 : w_ld_data;
               end
            end
            S_DONE: begin
               // The core still presents the finished instruction here, so i_req is not looked at.
               r_state    <= S_IDLE;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               r_mem_req  <= 1'b0;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = ((r_state == S_IDLE) & w_valid) | (r_state == S_REQ);
   assign o_done      = r_done;
   assign o_misalign  = r_misalign;
   assign o_ld_data   = r_ld_data;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_bmask = r_mem_bmask;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random accesses
// against a lane-arithmetic reference model, and reset/invalid-request sequences.
module tb_load_store_unit;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_req;
   logic        i_mem_wren;
   logic [2:0]  i_ld_sel;
   logic [1:0]  i_st_sel;
   logic [31:0] i_addr;
   logic [31:0] i_st_data;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_ld_data;
   logic        o_misalign;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   int total = 0;
   int bad   = 0;

   load_store_unit #(.ADDR_W(32)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (i_req),
      .i_mem_wren  (i_mem_wren),
      .i_ld_sel    (i_ld_sel),
      .i_st_sel    (i_st_sel),
      .i_addr      (i_addr),
      .i_st_data   (i_st_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_ld_data   (o_ld_data),
      .o_misalign  (o_misalign),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_bmask (o_mem_bmask),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        we;
      logic [2:0]  ld_sel;
      logic [1:0]  st_sel;
      logic [31:0] addr;
      logic [31:0] st_data;
      logic [31:0] rdata;
      int          waits;
      logic [31:0] e_addr;
      logic [3:0]  e_mask;
      logic [31:0] e_wdata;
      logic [31:0] e_ld;
      logic        e_mis;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic we, logic [2:0] ld, logic [1:0] st, logic [31:0] addr,
                               logic [31:0] sd, logic [31:0] rd, int waits, logic [31:0] ea,
                               logic [3:0] em, logic [31:0] ew, logic [31:0] el, logic emis);
      vec_t v;
      v.we = we; v.ld_sel = ld; v.st_sel = st; v.addr = addr; v.st_data = sd;
      v.rdata = rd; v.waits = waits; v.e_addr = ea; v.e_mask = em; v.e_wdata = ew;
      v.e_ld = el; v.e_mis = emis;
      return v;
   endfunction

   // Reference: lanes and extension from plain arithmetic on the byte address.
   function automatic vec_t ref_model(vec_t v);
      int          lane;
      logic [31:0] b;
      logic [31:0] h;
      logic        mis;
      lane = int'(v.addr % 32'd4);
      b    = (v.rdata >> (8 * lane)) & 32'h0000_00FF;
      h    = (v.rdata >> (16 * (lane / 2))) & 32'h0000_FFFF;
      mis  = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      if (v.we) mis = (v.st_sel == 2'd1 && lane % 2 != 0) || (v.st_sel == 2'd2 && lane != 0);
      else      mis = ((v.ld_sel == 3'd1 || v.ld_sel == 3'd4) && lane % 2 != 0) ||
                      (v.ld_sel == 3'd2 && lane != 0);
`endif
      v.e_mis  = mis;
      v.e_addr = v.addr - 32'(lane);
      v.e_mask = 4'b1111;
      v.e_wdata = v.st_data;
      v.e_ld   = 32'h0;
      if (v.we) begin
         if (v.st_sel == 2'd0) begin
            v.e_mask  = 4'(1 << lane);
            v.e_wdata = (v.st_data & 32'h0000_00FF) * 32'h0101_0101;
         end else if (v.st_sel == 2'd1) begin
            v.e_mask  = 4'(3 << (2 * (lane / 2)));
            v.e_wdata = (v.st_data & 32'h0000_FFFF) * 32'h0001_0001;
         end
      end else if (!mis) begin
         case (v.ld_sel)
            3'd0:    v.e_ld = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    v.e_ld = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd2:    v.e_ld = v.rdata;
            3'd3:    v.e_ld = b;
            default: v.e_ld = h;
         endcase
      end
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   // One full access: core holds i_req until DONE, memory acks after v.waits cycles.
   task automatic do_access(input vec_t v, input string nm);
      int          busy_cnt;
      int          done_cyc;
      int          req_cyc;
      int          fld_bad;
      logic [31:0] ld_act;
      logic        mis_act;
      logic [31:0] a_addr;
      logic [3:0]  a_mask;
      logic [31:0] a_wdata;
      logic        a_we;
      @(negedge i_clk);
      i_req = 1'b1; i_mem_wren = v.we; i_ld_sel = v.ld_sel; i_st_sel = v.st_sel;
      i_addr = v.addr; i_st_data = v.st_data; i_mem_ack = 1'b0;
      #1;
      busy_cnt = o_busy ? 1 : 0;
      done_cyc = -1; req_cyc = 0; fld_bad = 0; ld_act = 32'h0; mis_act = 1'b0;
      a_addr = 32'h0; a_mask = 4'h0; a_wdata = 32'h0; a_we = 1'b0;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         i_mem_ack   = 1'b0;
         i_mem_rdata = $urandom;
         if (o_done) begin
            done_cyc = c; ld_act = o_ld_data; mis_act = o_misalign;
         end
         if (o_mem_req) begin
            req_cyc++;
            if (req_cyc == 1) begin
               a_addr = o_mem_addr; a_mask = o_mem_bmask; a_wdata = o_mem_wdata; a_we = o_mem_we;
            end
            if (o_mem_addr !== v.e_addr || o_mem_bmask !== v.e_mask || o_mem_we !== v.we ||
                (v.we && o_mem_wdata !== v.e_wdata)) fld_bad++;
            if (req_cyc > v.waits) begin
               i_mem_ack = 1'b1; i_mem_rdata = v.rdata;
            end
         end
         #1;
         if (o_busy) busy_cnt++;
      end
      i_mem_ack = 1'b0;
      check({nm, ".done_cycle"}, done_cyc, v.e_mis ? 1 : 2 + v.waits);
      check({nm, ".busy_cycles"}, busy_cnt, v.e_mis ? 1 : 2 + v.waits);
      check({nm, ".req_cycles"}, req_cyc, v.e_mis ? 0 : v.waits + 1);
      check({nm, ".ld_data"}, ld_act, v.e_ld);
      check({nm, ".misalign"}, {31'h0, mis_act}, {31'h0, v.e_mis});
      if (!v.e_mis) begin
         check({nm, ".mem_addr"}, a_addr, v.e_addr);
         check({nm, ".mem_bmask"}, {28'h0, a_mask}, {28'h0, v.e_mask});
         check({nm, ".mem_we"}, {31'h0, a_we}, {31'h0, v.we});
         check({nm, ".req_stable"}, fld_bad, 0);
         if (v.we) check({nm, ".mem_wdata"}, a_wdata, v.e_wdata);
      end
      @(negedge i_clk);
      i_req = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check({nm, ".after_idle"}, {30'h0, o_mem_req, o_done}, 32'h0);
      check({nm, ".ld_hold"}, o_ld_data, v.e_ld);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      vec_t v;
      i_rst_n = 1'b0; i_req = 1'b0; i_mem_wren = 1'b0; i_ld_sel = 3'd0; i_st_sel = 2'd0;
      i_addr = 32'h0; i_st_data = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;

      // Directed vectors with hand-derived expectations.
      tbl.push_back(mk(1'b1, 3'd5, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2,
                       32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 2'd0, 32'h103, 32'h0, 32'h80112233, 0,
                       32'h100, 4'b1111, 32'h0, 32'hFFFFFF80, 1'b0));
      tbl.push_back(mk(1'b0, 3'd3, 2'd0, 32'h103, 32'h0, 32'h80112233, 0,
                       32'h100, 4'b1111, 32'h0, 32'h00000080, 1'b0));
      tbl.push_back(mk(1'b1, 3'd5, 2'd0, 32'h102, 32'h000000A5, 32'h0, 0,
                       32'h100, 4'b0100, 32'hA5A5A5A5, 32'h0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd1, 2'd0, 32'h102, 32'h0, 32'h80015566, 0,
                       32'h100, 4'b1111, 32'h0, 32'hFFFF8001, 1'b0));
      tbl.push_back(mk(1'b0, 3'd4, 2'd0, 32'h300, 32'h0, 32'h1234F00D, 1,
                       32'h300, 4'b1111, 32'h0, 32'h0000F00D, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 2'd0, 32'h101, 32'h0, 32'h00007F00, 3,
                       32'h100, 4'b1111, 32'h0, 32'h0000007F, 1'b0));
`ifdef LSU_MISALIGN_CHK_EN
      tbl.push_back(mk(1'b0, 3'd2, 2'd0, 32'h102, 32'h0, 32'h12345678, 0,
                       32'h100, 4'b1111, 32'h0, 32'h0, 1'b1));
      tbl.push_back(mk(1'b1, 3'd5, 2'd1, 32'h203, 32'h1234BEEF, 32'h0, 0,
                       32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b1));
`else
      tbl.push_back(mk(1'b0, 3'd2, 2'd0, 32'h102, 32'h0, 32'h12345678, 0,
                       32'h100, 4'b1111, 32'h0, 32'h12345678, 1'b0));
      tbl.push_back(mk(1'b1, 3'd5, 2'd1, 32'h203, 32'h1234BEEF, 32'h0, 0,
                       32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0));
`endif

      // Reset state.
      @(negedge i_clk);
      @(negedge i_clk);
      check("reset.ctrl", {27'h0, o_busy, o_done, o_misalign, o_mem_req, o_mem_we}, 32'h0);
      check("reset.mem_addr", o_mem_addr, 32'h0);
      check("reset.mem_wdata", o_mem_wdata, 32'h0);
      check("reset.mem_bmask", {28'h0, o_mem_bmask}, 32'h0);
      check("reset.ld_data", o_ld_data, 32'h0);
      i_rst_n = 1'b1;

      // Invalid load selects are ignored.
      cnt = 0;
      for (int s = 5; s <= 7; s++) begin
         @(negedge i_clk);
         i_req = 1'b1; i_mem_wren = 1'b0; i_ld_sel = 3'(s); i_addr = 32'h40;
         #1;
         if (o_busy || o_mem_req || o_done) cnt++;
      end
      @(negedge i_clk);
      if (o_busy || o_mem_req || o_done) cnt++;
      check("invalid.activity", cnt, 0);
      i_req = 1'b0;

      for (int i = 0; i < tbl.size(); i++) do_access(tbl[i], $sformatf("vec%0d", i));

      // Reset while a request is outstanding; a late ack must be ignored.
      @(negedge i_clk);
      i_req = 1'b1; i_mem_wren = 1'b0; i_ld_sel = 3'd2; i_addr = 32'h400; i_mem_ack = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check("rst_mid.req_up", {31'h0, o_mem_req}, 32'h1);
      i_req = 1'b0;
      i_rst_n = 1'b0;
      #1;
      check("rst_mid.req_drop", {30'h0, o_mem_req, o_busy}, 32'h0);
      check("rst_mid.mem_addr", o_mem_addr, 32'h0);
      check("rst_mid.mem_bmask", {28'h0, o_mem_bmask}, 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE0001;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         i_mem_ack = 1'b0;
         if (o_done || o_mem_req) cnt++;
      end
      check("rst_mid.stale_ack", cnt, 0);

      // Random accesses against the reference model.
      for (int i = 0; i < 40; i++) begin
         v.we      = 1'($urandom_range(0, 1));
         v.ld_sel  = 3'($urandom_range(0, 4));
         v.st_sel  = 2'($urandom_range(0, 2));
         v.addr    = $urandom;
         v.st_data = $urandom;
         v.rdata   = $urandom;
         v.waits   = int'($urandom_range(0, 3));
         v = ref_model(v);
         do_access(v, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit sitting between the core's execute stage and the data memory port. Consumes the load/store controls produced by instruction decode (`ld_sel` encoding, memory write enable, store width) and turns each request into a single word-aligned memory transaction. Memory handshake is request/acknowledge with arbitrary wait states. Stalls the core via `o_busy` until the access completes. Returns sign- or zero-extended load data.

## Interface
- `ADDR_W`, 32, byte-address width; data path fixed at 32 bits.
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  access request from execute stage.
- `i_mem_wren`  in  1  1 = store, 0 = load.
- `i_ld_sel`  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 none.
- `i_st_sel`  in  2  store funct3[1:0]: 0 SB, 1 SH, 2 SW.
- `i_addr`  in  ADDR_W  byte address (ALU result).
- `i_st_data`  in  32  rs2 value.
- `o_busy`  out  1  stall request to core.
- `o_done`  out  1  one-cycle completion pulse.
- `o_ld_data`  out  32  extended load result; valid while `o_done`.
- `o_misalign`  out  1  misaligned-access pulse, coincident with `o_done`.
- `o_mem_req`  out  1  memory request, held until acknowledged.
- `o_mem_we`  out  1  memory write.
- `o_mem_addr`  out  ADDR_W  word address, bits [1:0] = 0.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `o_mem_bmask`  out  4  byte enables.
- `i_mem_ack`  in  1  memory accepted write / returned read data.
- `i_mem_rdata`  in  32  read word, valid with `i_mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: request is valid when `i_req` is high and either `i_mem_wren`=1 or `i_ld_sel`≤4. A valid request is captured: address, sel, store data, direction.
  - Aligned request → REQ.
  - Misaligned request → DONE with misalign flag.
  - Invalid request (load with `i_ld_sel`≥5): ignored; no state change; `o_busy`=0.
- Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. A misaligned access never touches memory.
- REQ: `o_mem_req`=1 with stable address, `o_mem_we`, mask and wdata. On `i_mem_ack`:
  - load data is extracted from `i_mem_rdata`;
  - FSM → DONE.
- DONE: `o_done`=1; FSM → IDLE unconditionally. `i_req` is ignored in DONE, since it still carries the completed instruction.
- Store mask and data:
  - SB: mask `4'b0001<<addr[1:0]`, wdata = byte ×4.
  - SH: mask `4'b0011<<{addr[1],0}`, wdata = half ×2.
  - SW: mask `4'b1111`, wdata = word.
- Loads: mask `4'b1111`. Byte/half are selected by addr[1:0]/addr[1].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW is passed unchanged.
- `o_ld_data` = 0 for stores and misaligned accesses; it holds its value outside DONE.
- `i_mem_ack` outside REQ is ignored.

## Timing
- `o_busy` = (IDLE & valid request) | REQ. `o_busy` is combinational and low in DONE, so the core advances in the DONE cycle.
- Zero-wait memory: request seen in cycle N; REQ with ack in N+1; DONE in N+2. Each wait state adds one cycle.
- Misaligned access: request in N; DONE + `o_misalign` in N+1.
- All memory-side outputs are registered.
- Reset (asynchronous, at any point, including mid-REQ): FSM → IDLE. All outputs → 0, including `o_mem_req`, `o_mem_addr`, `o_mem_bmask` and `o_ld_data`. The in-flight access is abandoned and a later stale ack is ignored.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined: misalignment detection as above.
- Undefined: `o_misalign` is tied to 0. Low address bits beyond lane selection are ignored and every access goes to memory. For example, LW at 0x...3 reads the word at 0x...0, and SH with addr[0]=1 uses the addr[1] lane.

## Structure
- `lsu_pkg`:
  - `ld_sel_e` (LD_LB=0, LD_LH, LD_LW, LD_LBU, LD_LHU, LD_NONE=5);
  - `st_sel_e` (ST_SB=0, ST_SH, ST_SW);
  - FSM state enum.
  - The same `ld_sel_e` is shared with decode.
- Sub-module `lsu_align`: combinational store mask/replication and load extraction/extension. The top module keeps the FSM and registers.

## Test plan
- SW 0xDEADBEEF @0x100, ack after 2 waits → `o_mem_addr`=0x100, mask 1111, wdata 0xDEADBEEF; `o_busy` high for 4 cycles; `o_done` in N+4; `o_ld_data`=0.
- LB @0x103, zero-wait, rdata 0x80112233 → `o_ld_data`=0xFFFFFF80. LBU at the same address → 0x00000080. Both `o_done` in N+2.
- SB 0x000000A5 @0x102 → mask 0100, wdata 0xA5A5A5A5. LH @0x102 with rdata 0x8001xxxx → 0xFFFF8001.
- LW @0x102 with macro defined → no `o_mem_req`; `o_done`+`o_misalign` in N+1; `o_ld_data`=0. With macro undefined → read at 0x100.
- Assert `i_rst_n` low during REQ → `o_mem_req` drops immediately. After release, an ack with no request produces no `o_done`.
- Load with `i_ld_sel`=5 and `i_req`=1 → `o_busy`=0, no memory request, FSM stays IDLE.
